// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, with an
// internally expanded 11-entry round-key schedule that can be kept across blocks.
package aes_dec_pkg;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = gf_inv(x);
    return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction
endpackage

module key_gen (
  input  logic [3:0]   round_num,
  input  logic [127:0] key_in,
  output logic [127:0] key_out
);
  import aes_dec_pkg::*;

  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3, tmp;

  // Round constant for the round being generated
  always_comb begin
    case (round_num)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // One step of the forward key schedule
  always_comb begin
    w0 = key_in[127:96];
    w1 = key_in[95:64];
    w2 = key_in[63:32];
    w3 = key_in[31:0];
    tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h000000};
    key_out = {w0 ^ tmp, w0 ^ tmp ^ w1, w0 ^ tmp ^ w1 ^ w2, w0 ^ tmp ^ w1 ^ w2 ^ w3};
  end
endmodule

module aes_decrypt_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         key_new,
  input  logic [127:0] key_in,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out
);
  import aes_dec_pkg::*;

  if (NR != 10) begin : g_nr_check
    $error("aes_decrypt_iter supports only NR=10 (AES-128)");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXPAND = 3'd1,
    S_INIT   = 3'd2,
    S_ROUND  = 3'd3,
    S_FINAL  = 3'd4
  } fsm_e;

  // Byte i lives at bits [127-8i -: 8]; row = i%4, column = i/4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] state_q, state_d;
  logic [127:0] data_out_q, data_out_d;
  logic         busy_q, busy_d, done_q, done_d, key_valid_q, key_valid_d;
  logic [127:0] rk_q [0:10];
  logic         rk_we;
  logic [3:0]   rk_idx;
  logic [127:0] rk_wdata, prev_rk, kg_out, sr_sb;

  key_gen u_key_gen (
    .round_num (cnt_q),
    .key_in    (prev_rk),
    .key_out   (kg_out)
  );

  // Next-state, datapath and schedule-write control
  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    data_out_d  = data_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    key_valid_d = key_valid_q;
    rk_we       = 1'b0;
    rk_idx      = 4'd0;
    rk_wdata    = kg_out;
    prev_rk     = (cnt_q != 4'd0) ? rk_q[cnt_q - 4'd1] : rk_q[0];
    sr_sb       = inv_sub_bytes(inv_shift_rows(state_q));
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          state_d = data_in;
          busy_d  = 1'b1;
          if (key_new || !key_valid_q) begin
            rk_we       = 1'b1;
            rk_wdata    = key_in;
            key_valid_d = 1'b0;
            cnt_d       = 4'd1;
            fsm_d       = S_EXPAND;
          end else begin
            fsm_d = S_INIT;
          end
        end else begin
          fsm_d = S_IDLE;
        end
      end
      S_EXPAND: begin
        rk_we  = 1'b1;
        rk_idx = cnt_q;
        if (cnt_q == 4'd10) begin
          key_valid_d = 1'b1;
          fsm_d       = S_INIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_INIT: begin
        state_d = state_q ^ rk_q[10];
        cnt_d   = 4'd9;
        fsm_d   = S_ROUND;
      end
      S_ROUND: begin
        state_d = inv_mix_columns(sr_sb ^ rk_q[cnt_q]);
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          fsm_d = S_FINAL;
        end else begin
          fsm_d = S_ROUND;
        end
      end
      S_FINAL: begin
        data_out_d = sr_sb ^ rk_q[0];
        done_d     = 1'b1;
        busy_d     = 1'b0;
        fsm_d      = S_IDLE;
      end
      default: begin
        fsm_d  = S_IDLE;
        busy_d = 1'b0;
        cnt_d  = 4'd0;
      end
    endcase
  end

  // Control and data registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      cnt_q       <= 4'd0;
      state_q     <= 128'h0;
      data_out_q  <= 128'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      data_out_q  <= data_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Round-key schedule storage; contents are qualified by key_valid_q
  always_ff @(posedge clk) begin
    if (rk_we) rk_q[rk_idx] <= rk_wdata;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: FIPS-197 vectors, handshake corner
// cases and randomized round trips against a table-driven AES encryption model.
module tb_aes_decrypt_iter;
  logic         clk = 1'b0;
  logic         rst, start, key_new;
  logic [127:0] key_in, data_in, data_out;
  logic         busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  aes_decrypt_iter #(.NR(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key_new(key_new), .key_in(key_in),
    .data_in(data_in), .busy(busy), .done(done), .data_out(data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: S-box table built from the generator-walk construction.
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Issue one request and wait (bounded) for done; lat counts cycles after the accepting edge.
  task automatic run_op(input bit now, input logic [127:0] key, input logic [127:0] ct, input bit kn,
                        output int lat, output logic [127:0] res, output logic [127:0] hold);
    if (!now) @(negedge clk);
    start = 1'b1; key_in = key; data_in = ct; key_new = kn;
    @(negedge clk);
    start = 1'b0;
    key_new = 1'($urandom_range(0, 1));
    key_in  = {$urandom, $urandom, $urandom, $urandom};
    data_in = {$urandom, $urandom, $urandom, $urandom};
    hold = data_out;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = data_out;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key_new = 1'b0; key_in = 128'h0; data_in = 128'h0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (data_out !== 128'h0) begin n_fail++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
    rst = 1'b0;
  endtask

  task automatic test_fips_c1();
    int lat; logic [127:0] res, hold;
    run_op(1'b0, C1_KEY, C1_CT, 1'b1, lat, res, hold);
    n_checks++; if (lat !== 21) begin n_fail++; $display("FAIL c1_latency: got %0d expected 21", lat); end
    n_checks++; if (res !== C1_PT) begin n_fail++; $display("FAIL c1_plaintext: got %h expected %h", res, C1_PT); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL c1_done_pulse_width: got %b expected 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL c1_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_key_reuse();
    int lat; logic [127:0] res, hold;
    run_op(1'b0, {$urandom, $urandom, $urandom, $urandom}, C1_CT, 1'b0, lat, res, hold);
    n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL reuse_latency: got %0d expected 11", lat); end
    n_checks++; if (res !== C1_PT) begin n_fail++; $display("FAIL reuse_plaintext: got %h expected %h", res, C1_PT); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [127:0] res, hold;
    run_op(1'b0, B_KEY, B_CT, 1'b1, lat, res, hold);
    n_checks++; if (lat !== 21) begin n_fail++; $display("FAIL b_latency: got %0d expected 21", lat); end
    n_checks++; if (res !== B_PT) begin n_fail++; $display("FAIL b_plaintext: got %h expected %h", res, B_PT); end
    run_op(1'b1, C1_KEY, C1_CT, 1'b1, lat, res, hold);
    n_checks++; if (hold !== B_PT) begin n_fail++; $display("FAIL b2b_hold: got %h expected %h", hold, B_PT); end
    n_checks++; if (lat !== 21) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 21", lat); end
    n_checks++; if (res !== C1_PT) begin n_fail++; $display("FAIL b2b_plaintext: got %h expected %h", res, C1_PT); end
  endtask

  task automatic test_ignored_start();
    int cyc; int d0; bit early;
    @(negedge clk);
    start = 1'b1; key_in = B_KEY; data_in = B_CT; key_new = 1'b1;
    @(negedge clk);
    d0 = done_cnt; cyc = 0; early = 1'b0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1) early = 1'b1;
      start = (cyc == 3 || cyc == 15); data_in = C1_CT; key_in = C1_KEY; key_new = 1'b1;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_checks++; if (cyc !== 21) begin n_fail++; $display("FAIL ign_latency: got %0d expected 21", cyc); end
    n_checks++; if (data_out !== B_PT) begin n_fail++; $display("FAIL ign_plaintext: got %h expected %h", data_out, B_PT); end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL ign_busy_early_drop: got %b expected 0", early); end
    repeat (30) @(negedge clk);
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d expected 1", done_cnt - d0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_reset_abort();
    int d0; int lat; logic [127:0] res, hold;
    @(negedge clk);
    start = 1'b1; key_in = C1_KEY; data_in = C1_CT; key_new = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
    n_checks++; if (data_out !== 128'h0) begin n_fail++; $display("FAIL abort_data_out: got %h expected 0", data_out); end
    d0 = done_cnt;
    repeat (30) @(negedge clk);
    n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected %0d", done_cnt, d0); end
    run_op(1'b0, C1_KEY, C1_CT, 1'b0, lat, res, hold);
    n_checks++; if (lat !== 21) begin n_fail++; $display("FAIL abort_forced_latency: got %0d expected 21", lat); end
    n_checks++; if (res !== C1_PT) begin n_fail++; $display("FAIL abort_plaintext: got %h expected %h", res, C1_PT); end
  endtask

  task automatic test_random_roundtrip();
    logic [127:0] key_cur, pt, ct, res, hold, kdrv;
    bit kn; int lat;
    key_cur = C1_KEY;
    for (int v = 0; v < 1000; v++) begin
      kn = ($urandom_range(0, 2) == 0);
      if (kn) begin
        key_cur = {$urandom, $urandom, $urandom, $urandom};
        kdrv = key_cur;
      end else begin
        kdrv = {$urandom, $urandom, $urandom, $urandom};
      end
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = aes_encrypt(key_cur, pt);
      run_op(1'($urandom_range(0, 1)), kdrv, ct, kn, lat, res, hold);
      n_checks++;
      if (res !== pt) begin n_fail++; $display("FAIL rt_plaintext[%0d]: got %h expected %h", v, res, pt); end
      n_checks++;
      if (lat !== (kn ? 21 : 11)) begin n_fail++; $display("FAIL rt_latency[%0d]: got %0d expected %0d", v, lat, kn ? 21 : 11); end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_c1();
    test_key_reuse();
    test_back_to_back();
    test_ignored_start();
    test_reset_abort();
    test_random_roundtrip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_decrypt_iter.md
Name: aes_decrypt_iter

Overview:
Iterative AES-128 decryption core, the inverse of the existing encryption round datapath. It evaluates one inverse round per clock and holds an internally expanded 11-entry round-key schedule. The schedule is built by reusing the forward key_gen block, and can be retained across blocks that share a key. It sits beside the encryption core and exposes a start/busy/done handshake to the surrounding control logic.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported, and any other value is a compile-time error.

Ports:
clk       input   1    system clock, all state updates on rising edge
rst       input   1    synchronous reset, active-high
start     input   1    request decryption; sampled only in IDLE
key_new   input   1    with start: 1 = expand key_in, 0 = reuse stored schedule
key_in    input   128  cipher key; bit 127 = byte 0 (FIPS-197 order, same as encryption path)
data_in   input   128  ciphertext; same byte order; captured on the accepting edge
busy      output  1    high from the accepting edge until done
done      output  1    one-cycle pulse; data_out valid from this cycle
data_out  output  128  plaintext; holds until the next completion

Behaviour:
- Reset values and effects of rst:
  - outputs: busy=0, done=0, data_out=0.
  - internal: FSM=IDLE, key_valid=0, round counter=0; round-key registers don't-care.
- Datapath blocks: inv_shift_rows, inv_sub_bytes and inv_mix_column (new combinational blocks), plus the existing key_gen(round_num, key_in, key_out), where key_out = round key round_num derived from round key round_num-1 with Rcon(round_num).
- FSM states: IDLE, EXPAND, INIT, ROUND, FINAL.
- IDLE, on start=1 (accepting edge E0):
  - latch data_in into the state register and set busy=1.
  - if key_new=1 or key_valid=0: rk[0]<=key_in, cnt<=1, go to EXPAND.
  - else go to INIT, leaving rk[] untouched.
- EXPAND, each edge:
  - rk[cnt]<=key_gen(cnt, rk[cnt-1]) and cnt++.
  - after cnt=10 is written: key_valid<=1, go to INIT. This takes 10 edges.
- INIT, one edge: state<=state^rk[10], cnt<=9, go to ROUND.
- ROUND, edges for cnt=9 down to 1:
  - state<=InvMixColumns(InvSubBytes(InvShiftRows(state))^rk[cnt]), then cnt--.
  - after cnt=1, go to FINAL.
- FINAL, one edge:
  - data_out<=InvSubBytes(InvShiftRows(state))^rk[0].
  - done<=1 for exactly one cycle, busy<=0, go to IDLE.
- Latency (cycles from E0 to the cycle in which done is high):
  - key_new=1 or no valid schedule: 21 cycles.
  - reuse of stored schedule: 11 cycles.
- Back-to-back: start may be asserted in the same cycle done is high (FSM is in IDLE). That start is accepted, and data_out still holds the previous result until the next FINAL.
- start while busy=1: ignored, with no queuing; key_in and data_in changes during busy have no effect.
- key_new is ignored unless start=1 in IDLE.
- key_new=0 with key_valid=0 (after reset): full expansion is forced, so latency is 21.
- rst mid-operation: immediate return to IDLE with all reset values.
  - key_valid clears, so the next start always expands.
  - no done pulse is emitted for the aborted block.
- No arithmetic beyond GF(2^8) operations inside submodules. cnt is 4 bits and never wraps outside 0..10.

Test Plan:
- FIPS-197 C.1: rst, then start with key_new=1, key=000102030405060708090a0b0c0d0e0f, ct=69c4e0d86a7b0430d8cdb78070b4c55a -> done exactly 21 cycles after E0, data_out=00112233445566778899aabbccddeeff, rk[10]=13111d7fe3944a17f307a78b4d2b30c5.
- Key reuse: after C.1, start with key_new=0 and the same ct -> done after 11 cycles, same plaintext; key_in driven to garbage during the request has no effect.
- FIPS-197 Appendix B: key_new=1, key=2b7e151628aed2a6abf7158809cf4f3c, ct=3925841d02dc09fbdc118597196a0b32 -> data_out=3243f6a8885a308d313198a2e0370734. Then assert start in the done cycle with the C.1 key/ct and key_new=1 -> accepted, C.1 plaintext 21 cycles later.
- Ignored start: pulse start with a different ct at cycles 3 and 15 of a busy operation -> single done, original plaintext, busy never drops early.
- Reset abort: assert rst at cycle 8 of an expansion -> busy=0, done=0, data_out=0 next cycle, no later done. Then start with key_new=0 -> forced expansion, 21-cycle latency, correct plaintext.
- Cross-check: random key/plaintext pairs encrypted through the existing encryption core, then decrypted with mixed key_new values -> round-trip equality for 1000 vectors.
